// File: rtl/whac_pkg.sv
// Whac-A-Mole shared definitions: state codes, BCD arithmetic, LFSR taps.
// The timer imports the ST_* codes from here.
package whac_pkg;

    localparam logic [4:0] ST_IDLE  = 5'd0;
    localparam logic [4:0] ST_SET   = 5'd1;
    localparam logic [4:0] ST_READY = 5'd2;
    localparam logic [4:0] ST_PLAY  = 5'd3;
    localparam logic [4:0] ST_OVER  = 5'd4;

    typedef enum logic [4:0] {
        S_IDLE  = ST_IDLE,
        S_SET   = ST_SET,
        S_READY = ST_READY,
        S_PLAY  = ST_PLAY,
        S_OVER  = ST_OVER
    } state_e;

    // x^16 + x^14 + x^13 + x^11, Fibonacci form shifting left
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], ^(v & LFSR_TAPS)};
    endfunction

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'h99)
            r = v;
        else if (v[3:0] == 4'd9)
            r = {v[7:4] + 4'd1, 4'd0};
        else
            r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'h00)
            r = v;
        else if (v[3:0] == 4'd0)
            r = {v[7:4] - 4'd1, 4'd9};
        else
            r = {v[7:4], v[3:0] - 4'd1};
        return r;
    endfunction

    // Never repeat the hole the mole is leaving
    function automatic logic [7:0] mole_pick(
        input logic [2:0] idx,
        input logic [7:0] cur
    );
        logic [7:0] m;
        m = 8'd1 << idx;
        if (m == cur)
            m = 8'd1 << (idx + 3'd1);
        return m;
    endfunction

endpackage

// File: rtl/whac_mole_gen.sv
// Mole placement: free-running LFSR, dwell counter and no-repeat pick.
// place loads the first mole on PLAY entry; stop clears it on exit.
module whac_mole_gen
    import whac_pkg::*;
#(
    parameter int unsigned MOLE_CYC  = 50_000_000,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       place,
    input  logic       stop,
    input  logic       clear_on_hit,
    output logic [7:0] mole
);

    localparam int unsigned CW = $clog2(MOLE_CYC + 1);
    localparam logic [CW-1:0] LAST = CW'(MOLE_CYC - 1);

    logic [15:0]   lfsr;
    logic [CW-1:0] cnt;
    logic          wrap;

    assign wrap = en && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= LFSR_SEED;
            cnt  <= '0;
            mole <= 8'h00;
        end else begin
            lfsr <= lfsr_next(lfsr);

            if (!en || place || wrap)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;

            // A wrap outranks a hit clear so the next mole still appears
            if (stop || (!en && !place))
                mole <= 8'h00;
            else if (place || wrap)
                mole <= mole_pick(lfsr[2:0], mole);
            else if (clear_on_hit)
                mole <= 8'h00;
        end
    end

endmodule

// File: rtl/whac_game_ctrl.sv
// Whac-A-Mole game sequencer: state codes, hit detection and BCD score.
// Define WHAC_MISS_PENALTY_EN to make missed presses cost one point.
module whac_game_ctrl
    import whac_pkg::*;
#(
    parameter int unsigned MOLE_CYC  = 50_000_000,
    parameter int unsigned READY_CYC = 100_000_000,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_btn,
    input  logic [7:0] hole_btn,
    input  logic       timeover,
    output logic [4:0] state,
    output logic [7:0] mole,
    output logic [7:0] score,
    output logic       hit_pulse
);

    localparam int unsigned RW = $clog2(READY_CYC + 1);
    localparam logic [RW-1:0] RLAST = RW'(READY_CYC - 1);

    state_e        st;
    logic [RW-1:0] rdy_cnt;
    logic          start_q;
    logic [7:0]    hole_q;
    logic          start_rise;
    logic [7:0]    hole_rise;
    logic          in_play;
    logic          hit;
    logic          place;
    logic          stop;

    assign start_rise = start_btn & ~start_q;
    assign hole_rise  = hole_btn & ~hole_q;
    assign in_play    = (st == S_PLAY);
    assign hit        = in_play && |(hole_rise & mole);
    assign place      = (st == S_READY) && (rdy_cnt == RLAST);
    assign stop       = in_play && timeover;
    assign state      = st;

`ifdef WHAC_MISS_PENALTY_EN
    logic miss;
    assign miss = in_play && |hole_rise && !hit;
`endif

    whac_mole_gen #(
        .MOLE_CYC  (MOLE_CYC),
        .LFSR_SEED (LFSR_SEED)
    ) u_mole (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (in_play),
        .place        (place),
        .stop         (stop),
        .clear_on_hit (hit),
        .mole         (mole)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st        <= S_IDLE;
            rdy_cnt   <= '0;
            start_q   <= 1'b0;
            hole_q    <= 8'h00;
            score     <= 8'h00;
            hit_pulse <= 1'b0;
        end else begin
            start_q   <= start_btn;
            hole_q    <= hole_btn;
            hit_pulse <= 1'b0;
            unique case (st)
                S_IDLE: begin
                    if (start_rise) begin
                        st    <= S_SET;
                        score <= 8'h00;
                    end
                end
                S_SET: begin
                    // Zero time loaded: refuse to start
                    if (start_rise && !timeover) begin
                        st      <= S_READY;
                        rdy_cnt <= '0;
                    end
                end
                S_READY: begin
                    if (rdy_cnt == RLAST) begin
                        st      <= S_PLAY;
                        rdy_cnt <= '0;
                    end else begin
                        rdy_cnt <= rdy_cnt + 1'b1;
                    end
                end
                S_PLAY: begin
                    if (hit) begin
                        score     <= bcd_inc(score);
                        hit_pulse <= 1'b1;
                    end
`ifdef WHAC_MISS_PENALTY_EN
                    else if (miss) begin
                        score <= bcd_dec(score);
                    end
`endif
                    if (timeover)
                        st <= S_OVER;
                end
                S_OVER: begin
                    if (start_rise)
                        st <= S_IDLE;
                end
                default: st <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_whac_game_ctrl.sv
// Bench for whac_game_ctrl: random presses against a behavioural game model.
// Builds with or without WHAC_MISS_PENALTY_EN.
module tb_whac_game_ctrl;

    localparam int MOLE_CYC  = 8;
    localparam int READY_CYC = 10;
    localparam logic [15:0] SEED = 16'hACE1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_btn;
    logic [7:0] hole_btn;
    logic       timeover;
    logic [4:0] state;
    logic [7:0] mole;
    logic [7:0] score;
    logic       hit_pulse;

    int n_chk  = 0;
    int n_fail = 0;

    // game model: score kept as a plain decimal number
    int          m_state;
    int          m_score;
    logic [7:0]  m_mole;
    logic        m_pulse;
    logic [15:0] m_lfsr;
    int          m_ready_cycles;
    int          m_play_age;
    logic        p_start;
    logic [7:0]  p_hole;

    whac_game_ctrl #(
        .MOLE_CYC  (MOLE_CYC),
        .READY_CYC (READY_CYC),
        .LFSR_SEED (SEED)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_btn (start_btn),
        .hole_btn  (hole_btn),
        .timeover  (timeover),
        .state     (state),
        .mole      (mole),
        .score     (score),
        .hit_pulse (hit_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int s);
        return 8'(((s / 10) << 4) | (s % 10));
    endfunction

    function automatic logic [7:0] pick(input logic [15:0] l,
                                        input logic [7:0] cur);
        int idx;
        idx = int'(l) % 8;
        if ((8'd1 << idx) == cur)
            idx = (idx + 1) % 8;
        return 8'd1 << idx;
    endfunction

    task automatic model_reset();
        m_state        = 0;
        m_score        = 0;
        m_mole         = 8'h00;
        m_pulse        = 1'b0;
        m_lfsr         = SEED;
        m_ready_cycles = 0;
        m_play_age     = 0;
        p_start        = 1'b0;
        p_hole         = 8'h00;
    endtask

    task automatic check_outputs(input string pfx);
        chk({pfx, "_state"}, 16'(state), 16'(m_state));
        chk({pfx, "_mole"}, 16'(mole), 16'(m_mole));
        chk({pfx, "_score"}, 16'(score), 16'(to_bcd(m_score)));
        chk({pfx, "_hit"}, 16'(hit_pulse), 16'(m_pulse));
    endtask

    // one clock: predict from current inputs, clock, compare
    task automatic step();
        logic        srise;
        logic [7:0]  hrise;
        logic        hit;
        int          ns, nsc, nrc, nage;
        logic [7:0]  nm;
        logic        np;
        logic [15:0] nl;
        srise = start_btn && !p_start;
        hrise = hole_btn & ~p_hole;
        ns = m_state; nsc = m_score; nm = m_mole; np = 1'b0;
        nrc = m_ready_cycles; nage = m_play_age;
        nl = {m_lfsr[14:0],
              m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        case (m_state)
            0: if (srise) begin ns = 1; nsc = 0; end
            1: if (srise && !timeover) begin ns = 2; nrc = 0; end
            2: begin
                nrc = m_ready_cycles + 1;
                if (nrc == READY_CYC) begin
                    ns = 3; nage = 0;
                    nm = pick(m_lfsr, m_mole);
                end
            end
            3: begin
                hit = (m_mole != 0) && ((hrise & m_mole) != 0);
                if (hit) begin
                    nsc = (m_score < 99) ? m_score + 1 : 99;
                    np = 1'b1;
                    nm = 8'h00;
                end
`ifdef WHAC_MISS_PENALTY_EN
                else if (hrise != 0) begin
                    nsc = (m_score > 0) ? m_score - 1 : 0;
                end
`endif
                nage = m_play_age + 1;
                if (nage % MOLE_CYC == 0)
                    nm = pick(m_lfsr, m_mole);
                if (timeover) begin
                    ns = 4; nm = 8'h00;
                end
            end
            4: if (srise) ns = 0;
            default: ns = 0;
        endcase
        p_start = start_btn;
        p_hole  = hole_btn;
        @(posedge clk);
        #1;
        m_state = ns; m_score = nsc; m_mole = nm; m_pulse = np;
        m_ready_cycles = nrc; m_play_age = nage; m_lfsr = nl;
        check_outputs("cyc");
    endtask

    task automatic press_start();
        start_btn = 1'b1;
        step();
        start_btn = 1'b0;
        step();
    endtask

    task automatic wait_mole();
        for (int i = 0; i < 2 * MOLE_CYC && m_mole == 0; i++)
            step();
    endtask

    initial begin
        rst_n = 1'b0;
        start_btn = 1'b0;
        hole_btn = 8'h00;
        timeover = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_outputs("rst");
        rst_n = 1'b1;

        // game 1: SET refusal, hold test, random play, hit with timeover
        press_start();
        timeover = 1'b1;
        press_start();
        timeover = 1'b0;
        press_start();
        repeat (READY_CYC + 2) step();
        chk("play_entry", 16'(state), 16'd3);
        chk("mole_onehot", 16'($onehot(mole)), 16'd1);

        wait_mole();
        hole_btn = m_mole;
        repeat (4) step();
        hole_btn = 8'h00;
        step();

        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 3))
                0: hole_btn = m_mole;
                1: hole_btn = 8'($urandom);
                default: hole_btn = 8'h00;
            endcase
            step();
        end
        hole_btn = 8'h00;
        step();

        wait_mole();
        hole_btn = m_mole;
        timeover = 1'b1;
        step();
        chk("over_state", 16'(state), 16'd4);
        hole_btn = 8'h00;
        step();
        timeover = 1'b0;
        press_start();
        chk("idle_again", 16'(state), 16'd0);

        // game 2: drive score through 09->10 up to saturation
        press_start();
        press_start();
        repeat (READY_CYC + 2) step();
        for (int i = 0; i < 1600; i++) begin
            hole_btn = (i % 2 == 0) ? m_mole : 8'h00;
            step();
        end
        chk("saturate", 16'(score), 16'h0099);

        // asynchronous reset mid-PLAY, checked before any clock edge
        #2;
        rst_n = 1'b0;
        hole_btn = 8'h00;
        #1;
        model_reset();
        check_outputs("async_rst");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        press_start();
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
